// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of a single-port word SRAM: I-fetch (read-only)
// and D (read/write), round-robin on conflict, registered read data.
module sram_port_arbiter #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_ack,
   output logic                i_valid,
   output logic [DATA_W-1:0]   i_rdata,
   input  logic                d_req,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W/8-1:0] d_wen,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic                d_ack,
   output logic                d_valid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic [ADDR_W-1:0]   sram_addr,
   output logic                sram_read,
   output logic [DATA_W/8-1:0] sram_write,
   output logic [DATA_W-1:0]   sram_di,
   input  logic [DATA_W-1:0]   sram_do,
   output logic [CNT_W-1:0]    conflict_cnt
);

   typedef enum logic {
      LAST_I = 1'b0,
      LAST_D = 1'b1
   } last_t;

   last_t last_grant;
   last_t last_next;
   logic  grant_i;
   logic  grant_d;
   logic  d_is_read;

   assign d_is_read = ~|d_wen;

   // Tie goes to whichever port did not win the previous grant.
   always_comb begin
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      last_next = last_grant;
      if (!rst) begin
         if (i_req && d_req) begin
            grant_i = (last_grant == LAST_D);
            grant_d = (last_grant == LAST_I);
         end else begin
            grant_i = i_req;
            grant_d = d_req;
         end
         if (grant_i) last_next = LAST_I;
         if (grant_d) last_next = LAST_D;
      end
   end

   assign i_ack = grant_i;
   assign d_ack = grant_d;

   always_comb begin
      sram_addr  = '0;
      sram_read  = 1'b0;
      sram_write = '0;
      sram_di    = '0;
      if (grant_i) begin
         sram_addr = i_addr;
         sram_read = 1'b1;
      end else if (grant_d) begin
         sram_addr  = d_addr;
         sram_read  = d_is_read;
         sram_write = d_wen;
         sram_di    = d_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= LAST_D;
      end else begin
         last_grant <= last_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_valid <= 1'b0;
         i_rdata <= '0;
      end else begin
         i_valid <= grant_i;
         if (grant_i) i_rdata <= sram_do;
      end
   end

   // Writes pulse d_valid but leave d_rdata untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_valid <= 1'b0;
         d_rdata <= '0;
      end else begin
         d_valid <= grant_d;
         if (grant_d && d_is_read) d_rdata <= sram_do;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conflict_cnt <= '0;
      end else if (i_req && d_req && !(&conflict_cnt)) begin
         conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
   end

endmodule
